mem_wb_stage: RTL

- Parametrised MEM/WB pipeline register with a load-wait handshake. Sits between the memory-access stage and the register-file write port.
- Non-load instructions commit one cycle after acceptance.
- Loads are parked in a pending slot until memory returns data. Upstream is stalled while the load is pending.
- Drives a one-cycle write pulse, the selected writeback data, the R15 side-write, and pending-load status for the hazard unit.

---
 rtl/mem_wb_stage.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-wait handshake.
// Optional load timeout abort: define MEMWB_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int DATA_W      = 16,
    parameter int RADDR_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [RADDR_W-1:0] in_waddr,
    input  logic               in_wen,
    input  logic               in_memtoreg,
    input  logic [DATA_W-1:0]  in_r15,
    input  logic               in_r15en,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rvalid,
    output logic               wb_valid,
    output logic               wb_wen,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  wb_r15,
    output logic               wb_r15en,
    output logic               pend_valid,
    output logic [RADDR_W-1:0] pend_waddr,
    output logic               err_timeout
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic               valid_q, valid_d;
    logic               wen_q, wen_d;
    logic               r15en_q, r15en_d;
    logic [RADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  r15_q, r15_d;

    logic               p_wen_q, p_wen_d;
    logic               p_r15en_q, p_r15en_d;
    logic [RADDR_W-1:0] p_waddr_q, p_waddr_d;
    logic [DATA_W-1:0]  p_r15_q, p_r15_d;

    logic is_wait;
    logic accept;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT_CYC out of range");
    end

`ifdef MEMWB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign is_wait  = (state_q == WAIT);
    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        wen_d     = 1'b0;
        r15en_d   = 1'b0;
        waddr_d   = waddr_q;
        data_d    = data_q;
        r15_d     = r15_q;
        p_wen_d   = p_wen_q;
        p_r15en_d = p_r15en_q;
        p_waddr_d = p_waddr_q;
        p_r15_d   = p_r15_q;
`ifdef MEMWB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif
        unique case (1'b1)
            flush: begin
                state_d = IDLE;
            end
            accept & ~in_memtoreg: begin
                valid_d = 1'b1;
                wen_d   = in_wen;
                waddr_d = in_waddr;
                data_d  = in_alu;
                r15_d   = in_r15;
                r15en_d = in_r15en;
            end
            accept & in_memtoreg: begin
                state_d   = WAIT;
                p_wen_d   = in_wen;
                p_waddr_d = in_waddr;
                p_r15_d   = in_r15;
                p_r15en_d = in_r15en;
`ifdef MEMWB_TIMEOUT_EN
                cnt_d     = 16'd0;
`endif
            end
            is_wait & mem_rvalid & ~flush: begin
                state_d = IDLE;
                valid_d = 1'b1;
                wen_d   = p_wen_q;
                waddr_d = p_waddr_q;
                data_d  = mem_rdata;
                r15_d   = p_r15_q;
                r15en_d = p_r15en_q;
            end
            is_wait & ~mem_rvalid & ~flush: begin
`ifdef MEMWB_TIMEOUT_EN
                if (cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ~is_wait & ~accept & ~flush: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            wen_q     <= 1'b0;
            r15en_q   <= 1'b0;
            waddr_q   <= '0;
            data_q    <= '0;
            r15_q     <= '0;
            p_wen_q   <= 1'b0;
            p_r15en_q <= 1'b0;
            p_waddr_q <= '0;
            p_r15_q   <= '0;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q     <= 16'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            wen_q     <= wen_d;
            r15en_q   <= r15en_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            r15_q     <= r15_d;
            p_wen_q   <= p_wen_d;
            p_r15en_q <= p_r15en_d;
            p_waddr_q <= p_waddr_d;
            p_r15_q   <= p_r15_d;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign wb_valid   = valid_q;
    assign wb_wen     = wen_q;
    assign wb_r15en   = r15en_q;
    assign wb_waddr   = waddr_q;
    assign wb_data    = data_q;
    assign wb_r15     = r15_q;
    assign pend_valid = is_wait;
    assign pend_waddr = p_waddr_q;

endmodule
